issue_dispatch: RTL and testbench

- Dual-issue select stage directly downstream of the ISSUE buffer.
- Each cycle it inspects the two oldest buffered instructions (slot a = older, slot b = younger) and decides how many issue: 0, 1 or 2.
- It returns that count to the buffer combinationally as the pop count, and registers the issued instructions into the EX-stage pipeline registers.
- It tracks an in-flight load for load-use interlock and keeps issue statistics counters.

---
 rtl/issue_dispatch.sv | 142 ++++++++++++++
 tb/tb_issue_dispatch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_dispatch.sv
// Dual-issue select stage: picks 0/1/2 of the two oldest ISSUE-buffer entries per cycle,
// registers them into EX, tracks an in-flight load for load-use interlock, and counts issue outcomes.
package issue_dispatch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  ldst_type;
        logic        mem_we;
        logic [3:0]  br_type;
        logic [1:0]  csr_type;
        logic        ecode_we;
        logic        o_inst_lawful;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
    } pc_set_t;

endpackage

module issue_dispatch
    import issue_dispatch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  pc_set_t          i_PC_set1,
    input  pc_set_t          i_PC_set2,
    input  logic [1:0]       i_is_valid,
    input  logic             flush_BR,
    input  logic             stall_DCache,
    input  logic             stall_div,
    output logic [1:0]       o_usingNUM,
    output pc_set_t          o_PC_set_a,
    output pc_set_t          o_PC_set_b,
    output logic [1:0]       o_ex_valid,
    output logic [CNT_W-1:0] o_cnt_dual,
    output logic [CNT_W-1:0] o_cnt_single,
    output logic [CNT_W-1:0] o_cnt_bubble
);

    function automatic logic is_mem(input pc_set_t x);
        return |x.ldst_type;
    endfunction

    function automatic logic is_load(input pc_set_t x);
        return is_mem(x) & ~x.mem_we;
    endfunction

    function automatic logic is_br(input pc_set_t x);
        return ~x.br_type[0];
    endfunction

    function automatic logic is_solo(input pc_set_t x);
        return (|x.csr_type) | x.ecode_we | ~x.o_inst_lawful;
    endfunction

    function automatic logic writes(input pc_set_t x, input logic [4:0] r);
        return x.rf_we & (x.rf_rd == r) & (r != 5'd0);
    endfunction

    pc_set_t          ex_a_q, ex_b_q;
    logic [1:0]       ex_valid_q;
    logic             ld_valid_q, ld_valid_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [CNT_W-1:0] cnt_dual_q, cnt_single_q, cnt_bubble_q;
    logic [1:0]       use_d;

    logic stall, hold, lu_a, lu_b, raw_ab, waw_ab, pair_ok;

    assign stall  = stall_DCache | stall_div;
    assign hold   = stall | flush_BR;
    assign lu_a   = ld_valid_q & (ld_rd_q != 5'd0) &
                    ((ld_rd_q == i_PC_set1.rf_raddr1) | (ld_rd_q == i_PC_set1.rf_raddr2));
    assign lu_b   = ld_valid_q & (ld_rd_q != 5'd0) &
                    ((ld_rd_q == i_PC_set2.rf_raddr1) | (ld_rd_q == i_PC_set2.rf_raddr2));
    assign raw_ab = writes(i_PC_set1, i_PC_set2.rf_raddr1) | writes(i_PC_set1, i_PC_set2.rf_raddr2);
    assign waw_ab = i_PC_set1.rf_we & i_PC_set2.rf_we &
                    (i_PC_set1.rf_rd == i_PC_set2.rf_rd) & (i_PC_set1.rf_rd != 5'd0);

    assign pair_ok = i_is_valid[0] & ~lu_b & ~raw_ab & ~waw_ab
                   & ~(is_mem(i_PC_set1) & is_mem(i_PC_set2))
                   & ~(is_br(i_PC_set1) & is_br(i_PC_set2))
                   & ~is_solo(i_PC_set1) & ~is_solo(i_PC_set2);

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        use_d      = 2'd0;
        ld_valid_d = 1'b0;
        ld_rd_d    = 5'd0;
        if (rstn && !hold && i_is_valid[1] && !lu_a) begin
            use_d = pair_ok ? 2'd2 : 2'd1;
        end
        // The mem pairing rule guarantees at most one issued load.
        if (use_d != 2'd0 && is_load(i_PC_set1) && i_PC_set1.rf_we) begin
            ld_valid_d = 1'b1;
            ld_rd_d    = i_PC_set1.rf_rd;
        end else if (use_d == 2'd2 && is_load(i_PC_set2) && i_PC_set2.rf_we) begin
            ld_valid_d = 1'b1;
            ld_rd_d    = i_PC_set2.rf_rd;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_valid_q   <= 2'b00;
            ld_valid_q   <= 1'b0;
            ld_rd_q      <= 5'd0;
            cnt_dual_q   <= '0;
            cnt_single_q <= '0;
            cnt_bubble_q <= '0;
        end else if (flush_BR) begin
            ex_valid_q <= 2'b00;
            ld_valid_q <= 1'b0;
        end else if (!stall) begin
            ex_a_q     <= i_PC_set1;
            ex_b_q     <= i_PC_set2;
            ex_valid_q <= {use_d != 2'd0, use_d == 2'd2};
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
            case (use_d)
                2'd2:    cnt_dual_q   <= cnt_dual_q + CNT_W'(1);
                2'd1:    cnt_single_q <= cnt_single_q + CNT_W'(1);
                default: cnt_bubble_q <= cnt_bubble_q + CNT_W'(1);
            endcase
        end
    end

    assign o_usingNUM   = use_d;
    assign o_PC_set_a   = ex_a_q;
    assign o_PC_set_b   = ex_b_q;
    assign o_ex_valid   = ex_valid_q;
    assign o_cnt_dual   = cnt_dual_q;
    assign o_cnt_single = cnt_single_q;
    assign o_cnt_bubble = cnt_bubble_q;

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch: issue counts, EX registers, interlock, stall/flush and reset.
module tb_issue_dispatch;
    import issue_dispatch_pkg::*;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rstn;
    pc_set_t          pc1, pc2;
    logic [1:0]       valid;
    logic             flush_br, stall_dc, stall_dv;
    logic [1:0]       using_num;
    pc_set_t          ex_a, ex_b;
    logic [1:0]       ex_valid;
    logic [CNT_W-1:0] cnt_dual, cnt_single, cnt_bubble;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    issue_dispatch #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_PC_set1    (pc1),
        .i_PC_set2    (pc2),
        .i_is_valid   (valid),
        .flush_BR     (flush_br),
        .stall_DCache (stall_dc),
        .stall_div    (stall_dv),
        .o_usingNUM   (using_num),
        .o_PC_set_a   (ex_a),
        .o_PC_set_b   (ex_b),
        .o_ex_valid   (ex_valid),
        .o_cnt_dual   (cnt_dual),
        .o_cnt_single (cnt_single),
        .o_cnt_bubble (cnt_bubble)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int d, input int s, input int b);
        check({tag, ".dual"}, 64'(cnt_dual), 64'(d));
        check({tag, ".single"}, 64'(cnt_single), 64'(s));
        check({tag, ".bubble"}, 64'(cnt_bubble), 64'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pc_set_t base(input logic [31:0] pc);
        pc_set_t x;
        x = '0;
        x.pc            = pc;
        x.br_type       = 4'b0001;
        x.o_inst_lawful = 1'b1;
        return x;
    endfunction

    function automatic pc_set_t alu(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic [4:0] r1, input logic [4:0] r2);
        pc_set_t x;
        x = base(pc);
        x.rf_we = 1'b1;
        x.rf_rd = rd;
        x.rf_raddr1 = r1;
        x.rf_raddr2 = r2;
        return x;
    endfunction

    function automatic pc_set_t load(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rb);
        pc_set_t x;
        x = alu(pc, rd, rb, 5'd0);
        x.ldst_type = 4'd1;
        return x;
    endfunction

    function automatic pc_set_t branch(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
        pc_set_t x;
        x = base(pc);
        x.br_type = 4'b0010;
        x.rf_raddr1 = r1;
        x.rf_raddr2 = r2;
        return x;
    endfunction

    function automatic pc_set_t csrwr(input logic [31:0] pc);
        pc_set_t x;
        x = alu(pc, 5'd3, 5'd3, 5'd0);
        x.csr_type = 2'd1;
        return x;
    endfunction

    initial begin
        rstn = 1'b0; flush_br = 1'b0; stall_dc = 1'b0; stall_dv = 1'b0;
        pc1 = alu(32'h100, 5'd4, 5'd1, 5'd2);
        pc2 = alu(32'h104, 5'd5, 5'd3, 5'd8);
        valid = 2'b11;
        #2;
        check("rst.using", 64'(using_num), 64'd0);
        tick(); tick();
        check("rst.ex_valid", 64'(ex_valid), 64'd0);
        check("rst.pc_a", 64'(ex_a.pc), 64'd0);
        check_cnt("rst", 0, 0, 0);
        rstn = 1'b1;
        #1;

        // Independent ALU pair dual-issues
        check("alu_pair.using", 64'(using_num), 64'd2);
        tick();
        check("alu_pair.ex_valid", 64'(ex_valid), 64'b11);
        check("alu_pair.pc_a", 64'(ex_a.pc), 64'h100);
        check("alu_pair.pc_b", 64'(ex_b.pc), 64'h104);
        check_cnt("alu_pair", 1, 0, 0);

        // Load then dependent add: RAW split, then one load-use bubble
        pc1 = load(32'h200, 5'd6, 5'd1);
        pc2 = alu(32'h204, 5'd7, 5'd6, 5'd1);
        #1;
        check("ld_raw.using", 64'(using_num), 64'd1);
        tick();
        check("ld_raw.ex_valid", 64'(ex_valid), 64'b10);
        check("ld_raw.pc_a", 64'(ex_a.pc), 64'h200);
        pc1 = alu(32'h204, 5'd7, 5'd6, 5'd1);
        pc2 = alu(32'h208, 5'd9, 5'd7, 5'd11);
        #1;
        check("lu_hit.using", 64'(using_num), 64'd0);
        tick();
        check("lu_hit.ex_valid", 64'(ex_valid), 64'b00);
        check_cnt("lu_hit", 1, 1, 1);
        #1;
        check("after_lu.using", 64'(using_num), 64'd1);
        tick();
        check("after_lu.pc_a", 64'(ex_a.pc), 64'h204);

        // Two loads, two branches, csrwr in b then in a: each issues one
        pc1 = load(32'h300, 5'd12, 5'd1);
        pc2 = load(32'h304, 5'd13, 5'd2);
        #1;
        check("two_loads.using", 64'(using_num), 64'd1);
        tick();
        pc1 = branch(32'h308, 5'd1, 5'd2);
        pc2 = branch(32'h30c, 5'd3, 5'd4);
        #1;
        check("two_br.using", 64'(using_num), 64'd1);
        tick();
        pc1 = alu(32'h400, 5'd14, 5'd1, 5'd2);
        pc2 = csrwr(32'h404);
        #1;
        check("csr_b.using", 64'(using_num), 64'd1);
        tick();
        pc1 = csrwr(32'h404);
        pc2 = alu(32'h408, 5'd15, 5'd1, 5'd2);
        #1;
        check("csr_a.using", 64'(using_num), 64'd1);
        tick();
        check("csr_a.pc_a", 64'(ex_a.pc), 64'h404);
        check_cnt("singles", 1, 6, 1);

        // r0 destination is never a hazard
        pc1 = alu(32'h500, 5'd0, 5'd1, 5'd2);
        pc2 = alu(32'h504, 5'd0, 5'd0, 5'd0);
        #1;
        check("r0.using", 64'(using_num), 64'd2);
        tick();

        // Only slot a valid: b content ignored
        pc1 = alu(32'h600, 5'd17, 5'd1, 5'd2);
        pc2 = csrwr(32'h604);
        valid = 2'b10;
        #1;
        check("valid10.using", 64'(using_num), 64'd1);
        tick();
        check("valid10.ex_valid", 64'(ex_valid), 64'b10);
        check_cnt("valid10", 2, 7, 1);

        // Divider stall for three cycles, then resume
        pc1 = alu(32'h700, 5'd18, 5'd1, 5'd2);
        pc2 = alu(32'h704, 5'd19, 5'd3, 5'd4);
        valid = 2'b11;
        stall_dv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.using", 64'(using_num), 64'd0);
            tick();
            check("stall.ex_valid", 64'(ex_valid), 64'b10);
            check("stall.pc_a", 64'(ex_a.pc), 64'h600);
        end
        check_cnt("stall", 2, 7, 1);
        stall_dv = 1'b0;
        #1;
        check("resume.using", 64'(using_num), 64'd2);
        tick();
        check("resume.ex_valid", 64'(ex_valid), 64'b11);
        check_cnt("resume", 3, 7, 1);

        // Load into EX, then flush with DCache stall clears EX and the load tracker
        pc1 = load(32'h800, 5'd20, 5'd1);
        valid = 2'b10;
        #1;
        check("pre_flush.using", 64'(using_num), 64'd1);
        tick();
        pc1 = alu(32'h804, 5'd21, 5'd20, 5'd0);
        flush_br = 1'b1;
        stall_dc = 1'b1;
        #1;
        check("flush.using", 64'(using_num), 64'd0);
        tick();
        check("flush.ex_valid", 64'(ex_valid), 64'b00);
        check_cnt("flush", 3, 8, 1);
        flush_br = 1'b0;
        stall_dc = 1'b0;
        #1;
        check("post_flush.using", 64'(using_num), 64'd1);
        tick();
        check_cnt("post_flush", 3, 9, 1);

        // Asynchronous reset mid-stall
        valid = 2'b11;
        stall_dv = 1'b1;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst.using", 64'(using_num), 64'd0);
        check("async_rst.ex_valid", 64'(ex_valid), 64'd0);
        check_cnt("async_rst", 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
